// File: rtl/ifid_imm_stage_if.sv
// Valid/ready instruction stream carrying a fetched instruction and its PC.
// The producer uses the master modport; the consumer uses the slave modport.
interface ifid_imm_stage_if #(
   parameter int PC_W = 32
);
   logic            valid;
   logic            ready;
   logic [31:0]     inst;
   logic [PC_W-1:0] pc;

   modport master (output valid, output inst, output pc, input ready);
   modport slave  (input valid, input inst, input pc, output ready);
endinterface

// File: rtl/ifid_imm_stage.sv
// IF/ID stage: 2-entry skid buffer feeding the 16->32 immediate extender.
// Define IFID_PERF_EN to build the saturating stall-cycle counter on stall_cnt.
module ifid_imm_stage #(
   parameter int          PC_W     = 32,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   ifid_imm_stage_if.slave     in_if,
   ifid_imm_stage_if.master    out_if,
   output logic [15:0]         imm_16,
   output logic                sign,
   output logic [15:0]         stall_cnt
);

   logic            main_valid;
   logic [31:0]     main_inst;
   logic [PC_W-1:0] main_pc;
   logic            skid_valid;
   logic [31:0]     skid_inst;
   logic [PC_W-1:0] skid_pc;
   logic            in_ready;
   logic            accept;
   logic            fire;

   assign in_ready    = ~skid_valid & rst_n;
   assign accept      = in_if.valid & in_ready;
   assign fire        = main_valid & out_if.ready;

   assign in_if.ready = in_ready;
   assign out_if.valid = main_valid;
   assign out_if.inst  = main_inst;
   assign out_if.pc    = main_pc;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_inst  <= NOP_INST;
         main_pc    <= '0;
         skid_valid <= 1'b0;
         skid_inst  <= '0;
         skid_pc    <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         main_inst  <= NOP_INST;
         skid_valid <= 1'b0;
      end else if (!main_valid || fire) begin
         // Skid holds the older entry; a full skid also blocks any same-cycle accept.
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_inst  <= skid_inst;
            main_pc    <= skid_pc;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_inst  <= in_if.inst;
            main_pc    <= in_if.pc;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_inst  <= in_if.inst;
         skid_pc    <= in_if.pc;
      end
   end

   // andi/ori/xori/lui (opcodes 0x0C..0x0F) take a zero-extended immediate.
   assign imm_16 = main_inst[15:0];
   assign sign   = (main_inst[31:28] == 4'b0011) ? 1'b0 : 1'b1;

`ifdef IFID_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (main_valid && !out_if.ready && !flush && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ifid_imm_stage.sv
// Directed bench for ifid_imm_stage: table-driven streaming/decode vectors plus
// hand-written reset, backpressure, flush and stall-counter sequences.
module tb_ifid_imm_stage;

   localparam int PC_W = 32;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [15:0] imm_16;
   logic        sign;
   logic [15:0] stall_cnt;

   int checks;
   int errors;

   ifid_imm_stage_if #(.PC_W(PC_W)) up_if ();
   ifid_imm_stage_if #(.PC_W(PC_W)) dn_if ();

   ifid_imm_stage #(.PC_W(PC_W), .NOP_INST(32'h0000_0000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_if     (up_if),
      .out_if    (dn_if),
      .imm_16    (imm_16),
      .sign      (sign),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        in_valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        out_ready;
      logic        exp_valid;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
      logic        exp_in_ready;
      logic [15:0] exp_imm;
      logic        exp_sign;
   } vec_t;

   vec_t vecs[8];

`ifdef IFID_PERF_EN
   localparam logic [15:0] EXP_STALL5 = 16'd5;
`else
   localparam logic [15:0] EXP_STALL5 = 16'd0;
`endif

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
      up_if.valid  = v;
      up_if.inst   = inst;
      up_if.pc     = pc;
      dn_if.ready  = ordy;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      flush = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      flush  = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);

      //                in  inst          pc          ordy  ev  einst         epc         erdy eimm      esign
      vecs[0] = '{1'b1, 32'h3421_8001, 32'h0000_1000, 1'b1, 1'b1, 32'h3421_8001, 32'h0000_1000, 1'b1, 16'h8001, 1'b0};
      vecs[1] = '{1'b1, 32'h2021_8001, 32'h0000_1004, 1'b1, 1'b1, 32'h2021_8001, 32'h0000_1004, 1'b1, 16'h8001, 1'b1};
      vecs[2] = '{1'b1, 32'h3C01_1234, 32'h0000_1008, 1'b1, 1'b1, 32'h3C01_1234, 32'h0000_1008, 1'b1, 16'h1234, 1'b0};
      vecs[3] = '{1'b1, 32'h3001_FFFF, 32'h0000_100C, 1'b1, 1'b1, 32'h3001_FFFF, 32'h0000_100C, 1'b1, 16'hFFFF, 1'b0};
      vecs[4] = '{1'b1, 32'h3801_0005, 32'h0000_1010, 1'b1, 1'b1, 32'h3801_0005, 32'h0000_1010, 1'b1, 16'h0005, 1'b0};
      vecs[5] = '{1'b1, 32'h2C01_0007, 32'h0000_1014, 1'b1, 1'b1, 32'h2C01_0007, 32'h0000_1014, 1'b1, 16'h0007, 1'b1};
      vecs[6] = '{1'b1, 32'h4001_0009, 32'h0000_1018, 1'b1, 1'b1, 32'h4001_0009, 32'h0000_1018, 1'b1, 16'h0009, 1'b1};
      vecs[7] = '{1'b0, 32'hDEAD_BEEF, 32'h0000_101C, 1'b1, 1'b0, 32'h4001_0009, 32'h0000_1018, 1'b1, 16'h0009, 1'b1};

      // Reset held two edges, then released.
      tick();
      tick();
      check("rst_out_valid", {63'h0, dn_if.valid}, 64'h0);
      check("rst_in_ready",  {63'h0, up_if.ready}, 64'h0);
      check("rst_inst_out",  {32'h0, dn_if.inst},  64'h0);
      check("rst_stall_cnt", {48'h0, stall_cnt},   64'h0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready",  {63'h0, up_if.ready}, 64'h1);

      // Streaming and sign decode vectors.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].in_valid, vecs[i].inst, vecs[i].pc, vecs[i].out_ready);
         tick();
         check($sformatf("vec%0d_valid", i),    {63'h0, dn_if.valid}, {63'h0, vecs[i].exp_valid});
         check($sformatf("vec%0d_inst", i),     {32'h0, dn_if.inst},  {32'h0, vecs[i].exp_inst});
         check($sformatf("vec%0d_pc", i),       {32'h0, dn_if.pc},    {32'h0, vecs[i].exp_pc});
         check($sformatf("vec%0d_in_ready", i), {63'h0, up_if.ready}, {63'h0, vecs[i].exp_in_ready});
         check($sformatf("vec%0d_imm", i),      {48'h0, imm_16},      {48'h0, vecs[i].exp_imm});
         check($sformatf("vec%0d_sign", i),     {63'h0, sign},        {63'h0, vecs[i].exp_sign});
      end

      // Backpressure: A held, B in skid, C refused until drain.
      drive(1'b1, 32'hA000_0001, 32'h0000_2000, 1'b0);
      tick();
      check("bp_a_valid", {63'h0, dn_if.valid}, 64'h1);
      check("bp_a_inst",  {32'h0, dn_if.inst},  {32'h0, 32'hA000_0001});
      check("bp_a_rdy",   {63'h0, up_if.ready}, 64'h1);
      drive(1'b1, 32'hB000_0002, 32'h0000_2004, 1'b0);
      tick();
      check("bp_b_inst",  {32'h0, dn_if.inst},  {32'h0, 32'hA000_0001});
      check("bp_b_rdy",   {63'h0, up_if.ready}, 64'h0);
      drive(1'b1, 32'hC000_0003, 32'h0000_2008, 1'b0);
      tick();
      check("bp_c_inst",  {32'h0, dn_if.inst},  {32'h0, 32'hA000_0001});
      check("bp_c_pc",    {32'h0, dn_if.pc},    {32'h0, 32'h0000_2000});
      check("bp_c_rdy",   {63'h0, up_if.ready}, 64'h0);
      drive(1'b1, 32'hC000_0003, 32'h0000_2008, 1'b1);
      tick();
      check("bp_drain_b",     {32'h0, dn_if.inst},  {32'h0, 32'hB000_0002});
      check("bp_drain_b_pc",  {32'h0, dn_if.pc},    {32'h0, 32'h0000_2004});
      check("bp_drain_rdy",   {63'h0, up_if.ready}, 64'h1);
      tick();
      check("bp_drain_c",     {32'h0, dn_if.inst},  {32'h0, 32'hC000_0003});
      check("bp_drain_c_val", {63'h0, dn_if.valid}, 64'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      check("bp_empty",       {63'h0, dn_if.valid}, 64'h0);

      // Flush with both entries full and a same-cycle offer.
      drive(1'b1, 32'hA100_0001, 32'h0000_3000, 1'b0);
      tick();
      drive(1'b1, 32'hB100_0002, 32'h0000_3004, 1'b0);
      tick();
      check("fl_full_rdy", {63'h0, up_if.ready}, 64'h0);
      drive(1'b1, 32'hD100_0004, 32'h0000_3008, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_valid", {63'h0, dn_if.valid}, 64'h0);
      check("fl_inst",  {32'h0, dn_if.inst},  64'h0);
      check("fl_rdy",   {63'h0, up_if.ready}, 64'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      tick();
      check("fl_after_valid", {63'h0, dn_if.valid}, 64'h0);
      check("fl_after_inst",  {32'h0, dn_if.inst},  64'h0);

      // Reset while skid is full.
      drive(1'b1, 32'hA200_0001, 32'h0000_4000, 1'b0);
      tick();
      drive(1'b1, 32'hB200_0002, 32'h0000_4004, 1'b0);
      tick();
      check("rs_full_rdy", {63'h0, up_if.ready}, 64'h0);
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      check("rs_valid",   {63'h0, dn_if.valid}, 64'h0);
      check("rs_rdy_low", {63'h0, up_if.ready}, 64'h0);
      check("rs_stall",   {48'h0, stall_cnt},   64'h0);
      rst_n = 1'b1;
      #1;
      check("rs_rdy_high", {63'h0, up_if.ready}, 64'h1);
      tick();
      check("rs_skid_gone", {63'h0, dn_if.valid}, 64'h0);

      // Stall counter: five edges with out_valid=1 and out_ready=0.
      do_reset();
      drive(1'b1, 32'hA300_0001, 32'h0000_5000, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      check("st_cnt",   {48'h0, stall_cnt}, {48'h0, EXP_STALL5});
      check("st_inst",  {32'h0, dn_if.inst}, {32'h0, 32'hA300_0001});
      check("st_valid", {63'h0, dn_if.valid}, 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
